game_master: RTL
================

Name: game_master

Overview:
- Top-level turn sequencer for one tic-tac-toe match.
- Owns both player boards and accepts moves from the two players in alternation.
- After each legal move it acts as the initiator of the req/ready/valid judge protocol, then either passes the turn to the other player or declares the game over.
- Sits between player input logic (buttons/AI) and the judge block.

Parameters:
ROWS, 3, board rows
COLS, 3, board columns
POS_W, $clog2(ROWS*COLS), width of the move position index
TIMEOUT_CYCLES, 1000, maximum WAIT_MOVE cycles per turn (used only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a new game (level sampled)
first_player  input  1  sampled with start; 0 = A moves first, 1 = B moves first
move_valid  input  1  move offered
move_pos  input  POS_W  cell index, row-major, 0..ROWS*COLS-1
move_ready  output  1  high only in WAIT_MOVE
move_accept  output  1  1-cycle pulse on a legal move
move_reject  output  1  1-cycle pulse on an illegal move
turn  output  1  player to move: 0 = A, 1 = B
board_a  output  ROWS*COLS  A's occupied cells
board_b  output  ROWS*COLS  B's occupied cells
judge_req  output  1  judge request, exactly 1 cycle
judge_ready  input  1  judge idle
judge_valid  input  1  judge result strobe
judge_end  input  1  judge end_of_game
judge_win_a  input  1  judge win_a
judge_win_b  input  1  judge win_b
in_progress  output  1  game active
game_over  output  1  game finished
winner  output  2  00 draw/none, 01 A, 10 B
timeout  output  1  sticky; game ended by move timeout

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; boards=0; turn=0; judge_req=0; in_progress=0; game_over=0; winner=00; timeout=0; move_accept=0; move_reject=0.
- States: IDLE, WAIT_MOVE, REQ_WAIT, WAIT_RESULT, DONE.
- IDLE / DONE:
  - start=1 → clear boards, game_over, winner and timeout; turn<=first_player; in_progress<=1; go to WAIT_MOVE.
- WAIT_MOVE (move_ready=1):
  - On move_valid, a move is illegal when move_pos ≥ ROWS*COLS, or board_a[pos] | board_b[pos] is already set.
  - Illegal → move_reject pulse next cycle; boards and turn unchanged; stay in WAIT_MOVE.
  - Legal → set the current player's board bit; move_accept pulse next cycle; go to REQ_WAIT.
  - start=1 here aborts the game and restarts exactly as from IDLE; start wins over a simultaneous move_valid.
- REQ_WAIT:
  - Wait for judge_ready=1. The judge holds ready low for ≥1 cycle after reset; that is expected.
  - On ready: judge_req<=1 for exactly one cycle; go to WAIT_RESULT.
- WAIT_RESULT:
  - Boards must stay stable; no moves are taken.
  - judge_valid=1 →
    - judge_end=0 → toggle turn; go to WAIT_MOVE.
    - judge_end=1 → winner = {judge_win_b, judge_win_a}; game_over<=1; in_progress<=0; go to DONE.
  - Assertion: judge_win_a and judge_win_b are never both 1.
- start is ignored in REQ_WAIT and WAIT_RESULT. This prevents a stale judge_valid from being consumed by a new game.
- judge_valid outside WAIT_RESULT is ignored.
- Latency:
  - Legal move sampled at edge t → board visible at t+1.
  - judge_req rises no earlier than t+2.
  - turn toggles on the edge after judge_valid is sampled.
- Reset mid-operation (any state, including WAIT_RESULT) returns to IDLE immediately. The judge shares the same reset.

Optional Feature:
MOVE_TIMEOUT_EN
- Defined: a counter runs while in WAIT_MOVE and clears on any accepted move or restart. Rejected moves do not clear it.
- When the counter reaches TIMEOUT_CYCLES, the player to move forfeits: winner = other player; game_over=1; timeout=1; in_progress=0; go to DONE; no judge request is issued.
- Undefined: no counter is built and timeout is tied to 0.

Test Plan:
1. Row win for A: reset, start with first_player=0; moves 0,3,1,4,2 → after the 5th judge_valid: board_a=9'b000000111, board_b=9'b000011000, game_over=1, winner=01. Exactly 5 judge_req pulses.
2. Draw: moves A0,B1,A2,B4,A3,B5,A7,B6,A8 → board_a=9'b110001101, board_b=9'b001110010, game_over=1, winner=00.
3. Illegal moves: A plays 4, then B plays 4 → move_reject, turn stays 1, no judge_req. Then B plays 9 → move_reject.
4. Handshake stall: hold judge_ready=0 for 20 cycles after a legal move → judge_req stays 0 and rises 1 cycle after ready rises. A move_valid offered during WAIT_RESULT → move_ready=0 and the board is unchanged.
5. Restart: in DONE, assert start with first_player=1 → boards=0, turn=1, in_progress=1, winner=00.
6. (MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=16) Start, then no move for 16 cycles with A to move → timeout=1, winner=10, game_over=1.

Source files
------------

// File: rtl/game_master.sv
// Tic-tac-toe turn sequencer: owns both boards, alternates players, runs the judge handshake.
// Optional build macro MOVE_TIMEOUT_EN adds a per-turn forfeit after TIMEOUT_CYCLES idle cycles.
module game_master #(
   parameter int ROWS           = 3,
   parameter int COLS           = 3,
   parameter int POS_W          = $clog2(ROWS*COLS),
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 first_player,
   input  logic                 move_valid,
   input  logic [POS_W-1:0]     move_pos,
   output logic                 move_ready,
   output logic                 move_accept,
   output logic                 move_reject,
   output logic                 turn,
   output logic [ROWS*COLS-1:0] board_a,
   output logic [ROWS*COLS-1:0] board_b,
   output logic                 judge_req,
   input  logic                 judge_ready,
   input  logic                 judge_valid,
   input  logic                 judge_end,
   input  logic                 judge_win_a,
   input  logic                 judge_win_b,
   output logic                 in_progress,
   output logic                 game_over,
   output logic [1:0]           winner,
   output logic                 timeout
);

   localparam int CELLS = ROWS * COLS;

   typedef enum logic [2:0] {IDLE, WAIT_MOVE, REQ_WAIT, WAIT_RESULT, DONE} state_t;

   state_t           state_reg;
   logic [CELLS-1:0] board_a_reg;
   logic [CELLS-1:0] board_b_reg;
   logic [CELLS-1:0] pos_hot;
   logic             move_ready_reg;
   logic             move_accept_reg;
   logic             move_reject_reg;
   logic             turn_reg;
   logic             judge_req_reg;
   logic             in_progress_reg;
   logic             game_over_reg;
   logic [1:0]       winner_reg;
   logic             legal;
   logic             restart;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   // One-hot decode of the offered cell; an out-of-range index decodes to all zeros.
   genvar gi;
   generate
      for (gi = 0; gi < CELLS; gi++) begin : g_pos_hot
         assign pos_hot[gi] = (move_pos == POS_W'(gi));
      end
   endgenerate

   assign legal   = move_valid && (|pos_hot) && !(|(pos_hot & (board_a_reg | board_b_reg)));
   assign restart = start && (state_reg == IDLE || state_reg == WAIT_MOVE || state_reg == DONE);

`ifdef MOVE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_reg;
   logic             timeout_reg;
   logic             expired;
   assign expired = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout = timeout_reg;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         board_a_reg     <= '0;
         board_b_reg     <= '0;
         move_ready_reg  <= 1'b0;
         move_accept_reg <= 1'b0;
         move_reject_reg <= 1'b0;
         turn_reg        <= 1'b0;
         judge_req_reg   <= 1'b0;
         in_progress_reg <= 1'b0;
         game_over_reg   <= 1'b0;
         winner_reg      <= 2'b00;
`ifdef MOVE_TIMEOUT_EN
         wait_cnt_reg    <= '0;
         timeout_reg     <= 1'b0;
`endif
      end else begin
         move_accept_reg <= 1'b0;
         move_reject_reg <= 1'b0;
         judge_req_reg   <= 1'b0;
         if (restart) begin
            board_a_reg     <= '0;
            board_b_reg     <= '0;
            game_over_reg   <= 1'b0;
            winner_reg      <= 2'b00;
            turn_reg        <= first_player;
            in_progress_reg <= 1'b1;
            move_ready_reg  <= 1'b1;
            state_reg       <= WAIT_MOVE;
`ifdef MOVE_TIMEOUT_EN
            wait_cnt_reg    <= '0;
            timeout_reg     <= 1'b0;
`endif
         end else begin
            case (state_reg)
               WAIT_MOVE: begin
                  move_reject_reg <= move_valid && !legal;
                  if (legal) begin
                     if (turn_reg) board_b_reg <= board_b_reg | pos_hot;
                     else          board_a_reg <= board_a_reg | pos_hot;
                     move_accept_reg <= 1'b1;
                     move_ready_reg  <= 1'b0;
                     state_reg       <= REQ_WAIT;
`ifdef MOVE_TIMEOUT_EN
                     wait_cnt_reg    <= '0;
                  end else if (expired) begin
                     // The idle player forfeits; the judge is not consulted.
                     winner_reg      <= turn_reg ? 2'b01 : 2'b10;
                     game_over_reg   <= 1'b1;
                     timeout_reg     <= 1'b1;
                     in_progress_reg <= 1'b0;
                     move_ready_reg  <= 1'b0;
                     state_reg       <= DONE;
                  end else begin
                     wait_cnt_reg    <= wait_cnt_reg + CNT_W'(1);
`endif
                  end
               end
               REQ_WAIT: begin
                  if (judge_ready) begin
                     judge_req_reg <= 1'b1;
                     state_reg     <= WAIT_RESULT;
                  end
               end
               WAIT_RESULT: begin
                  if (judge_valid) begin
                     if (!judge_end) begin
                        turn_reg       <= !turn_reg;
                        move_ready_reg <= 1'b1;
                        state_reg      <= WAIT_MOVE;
                     end else begin
                        winner_reg      <= {judge_win_b, judge_win_a};
                        game_over_reg   <= 1'b1;
                        in_progress_reg <= 1'b0;
                        state_reg       <= DONE;
                     end
                  end
               end
               default: begin
                  // IDLE and DONE only leave on start, handled above.
               end
            endcase
         end
      end
   end

   win_exclusive: assert property (@(posedge clk) disable iff (reset)
      (state_reg == WAIT_RESULT && judge_valid) |-> !(judge_win_a && judge_win_b));

   assign move_ready  = move_ready_reg;
   assign move_accept = move_accept_reg;
   assign move_reject = move_reject_reg;
   assign turn        = turn_reg;
   assign board_a     = board_a_reg;
   assign board_b     = board_b_reg;
   assign judge_req   = judge_req_reg;
   assign in_progress = in_progress_reg;
   assign game_over   = game_over_reg;
   assign winner      = winner_reg;

endmodule
